// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  // One UART payload byte.
  typedef logic [7:0] byte_t;

  // Transmit handshake FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  localparam int DEFAULT_DEPTH_LOG2   = 4;
  localparam int DEFAULT_BUSY_TIMEOUT = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage array: 2^ADDR_W entries, one write port, one asynchronous
// read port. Contents are not reset; occupancy tracking lives with the user.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  byte_t             wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output byte_t             rd_data
);

  byte_t mem_r [2**ADDR_W];

  // Capture the incoming byte at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through its write/busy handshake.
// Every dequeued byte gets exactly one single-cycle write strobe.
// Optional macro UART_TX_FIFO_FLUSH_EN adds flush_i, which empties the queue
// without disturbing the byte currently being handed to the transmitter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic              clock_i,
  input  logic              reset_i,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic [7:0]        data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [7:0]        uart_data_o,
  output logic              uart_write_o,
  input  logic              uart_busy_i,
  output logic [DEPTH_LOG2:0] count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_C   = CNT_W'(1'b1) << DEPTH_LOG2;
  localparam logic [3:0]          TIMEOUT_C = 4'(BUSY_TIMEOUT);

  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  empty_r;
  logic                  full_r;
  byte_t                 head_s;
  byte_t                 uart_data_r;
  logic                  uart_write_r;
  tx_state_t             state_r;
  logic [3:0]            timeout_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  flush_s;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush_s = flush_i;
`else
  assign flush_s = 1'b0;
`endif

  uart_fifo_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clock_i),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_i),
    .rd_addr (rd_ptr_r),
    .rd_data (head_s)
  );

  // Qualify push/pop for this edge and work out the next occupancy.
  always_comb begin
    push_s      = valid_i && !full_r && !flush_s;
    pop_s       = (state_r == IDLE) && !empty_r && !uart_busy_i && !flush_s;
    count_nxt_s = count_r;
    if (flush_s) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointers and registered occupancy flags.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= {DEPTH_LOG2{1'b0}};
        rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1'b1);
        end
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  // Transmit handshake: strobe once per byte, then wait out the frame.
  // If busy never rises, give up after BUSY_TIMEOUT cycles and move on.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r      <= IDLE;
      uart_write_r <= 1'b0;
      uart_data_r  <= 8'h00;
      timeout_r    <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          uart_write_r <= 1'b0;
          if (pop_s) begin
            uart_data_r  <= head_s;
            uart_write_r <= 1'b1;
            state_r      <= WRITE;
          end
        end
        WRITE: begin
          uart_write_r <= 1'b0;
          timeout_r    <= 4'd0;
          state_r      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          uart_write_r <= 1'b0;
          if (uart_busy_i) begin
            state_r <= WAIT_DONE;
          end else if ((timeout_r + 4'd1) == TIMEOUT_C) begin
            state_r <= IDLE;
          end else begin
            timeout_r <= timeout_r + 4'd1;
          end
        end
        WAIT_DONE: begin
          uart_write_r <= 1'b0;
          if (!uart_busy_i) begin
            state_r <= IDLE;
          end
        end
        default: begin
          uart_write_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign ready_o      = !full_r;
  assign full_o       = full_r;
  assign empty_o      = empty_r;
  assign count_o      = count_r;
  assign uart_data_o  = uart_data_r;
  assign uart_write_o = uart_write_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based reference of bytes
// owed to the transmitter, a simple transmitter model, and directed phases.
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2   = 4;
  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 4;
  localparam int TX_NEVER     = 0;
  localparam int TX_RESP      = 1;
  localparam int TX_HOLD      = 2;

  logic                clock_i;
  logic                reset_i;
  logic [7:0]          data_i;
  logic                valid_i;
  logic                ready_o;
  logic [7:0]          uart_data_o;
  logic                uart_write_o;
  logic                uart_busy_i;
  logic [DEPTH_LOG2:0] count_o;
  logic                empty_o;
  logic                full_o;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic                flush_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pushed   = 0;
  int strobes  = 0;
  int tx_mode  = TX_NEVER;
  int frame_len = 10;
  int frame_left = 0;
  int start_pending = 0;
  int first, t0, s0;
  logic [7:0] exp_q [$];
  int         strobe_cyc [$];
  logic       prev_write = 1'b0;

  uart_tx_fifo #(
    .DEPTH_LOG2   (DEPTH_LOG2),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
`ifdef UART_TX_FIFO_FLUSH_EN
    .flush_i      (flush_i),
`endif
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .uart_data_o  (uart_data_o),
    .uart_write_o (uart_write_o),
    .uart_busy_i  (uart_busy_i),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  initial begin
    forever begin
      @(posedge clock_i);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int occ();
    return pushed - strobes;
  endfunction

  task automatic step();
    @(negedge clock_i);
    #1;
  endtask

  task automatic drive_push(input logic [7:0] b);
    data_i  = b;
    valid_i = 1'b1;
    if (occ() < DEPTH) begin
      exp_q.push_back(b);
      pushed++;
    end
    step();
    valid_i = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count_o), 32'(occ()));
    check({tag, "_empty"}, 32'(empty_o), 32'(occ() == 0));
    check({tag, "_full"},  32'(full_o),  32'(occ() == DEPTH));
    check({tag, "_ready"}, 32'(ready_o), 32'(occ() != DEPTH));
  endtask

  task automatic wait_strobes(input string tag, input int target, input int budget);
    int n = 0;
    while (strobes < target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(strobes), 32'(target));
  endtask

  // Transmitter model: busy rises the cycle after a strobe and stays high
  // for frame_len cycles (TX_RESP), is stuck high (TX_HOLD) or never rises.
  initial begin
    uart_busy_i = 1'b0;
    forever begin
      @(negedge clock_i);
      if (tx_mode == TX_HOLD) begin
        uart_busy_i = 1'b1;
        frame_left = 0;
        start_pending = 0;
      end else if (tx_mode == TX_NEVER) begin
        uart_busy_i = 1'b0;
        frame_left = 0;
        start_pending = 0;
      end else begin
        if (start_pending != 0) begin
          frame_left = frame_len;
          start_pending = 0;
        end else if (frame_left > 0) begin
          frame_left--;
        end
        uart_busy_i = (frame_left > 0);
        if (uart_write_o === 1'b1) start_pending = 1;
      end
    end
  end

  // Strobe monitor: each strobe must carry the oldest owed byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock_i);
      if (uart_write_o === 1'b1) begin
        check("no_back_to_back", 32'(prev_write), 32'd0);
        check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("strobe_data", 32'(uart_data_o), 32'(e));
        end
        strobe_cyc.push_back(cyc);
        strobes++;
      end
      prev_write = uart_write_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=%0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
`ifdef UART_TX_FIFO_FLUSH_EN
    flush_i = 1'b0;
`endif
    repeat (3) step();
    check_status("rst");
    check("rst_write", 32'(uart_write_o), 32'd0);
    check("rst_data", 32'(uart_data_o), 32'h00);
    reset_i = 1'b1;
    step();
    check_status("post_rst");

    // Single byte with a responsive transmitter.
    tx_mode = TX_RESP;
    frame_len = 10;
    first = strobe_cyc.size();
    t0 = cyc;
    drive_push(8'hA5);
    check_status("a_push");
    repeat (20) step();
    check("a_strobes", 32'(strobes), 32'd1);
    check("a_latency", 32'(strobe_cyc[first]), 32'(t0 + 2));
    check_status("a_done");

    // Fill to full with busy stuck high, overflow attempt, then drain.
    tx_mode = TX_HOLD;
    step();
    step();
    for (int i = 0; i < 16; i++) drive_push(8'(i));
    check_status("b_full");
    check("b_full_flag", 32'(full_o), 32'd1);
    drive_push(8'hFF);
    check_status("b_reject");
    tx_mode = TX_RESP;
    wait_strobes("b_drain", pushed, 400);
    check_status("b_drained");
    repeat (15) step();

    // Same-cycle push and pop at count 3, then random traffic across wrap.
    tx_mode = TX_HOLD;
    frame_len = 2;
    step();
    step();
    for (int i = 0; i < 3; i++) drive_push(8'($urandom));
    check_status("c_three");
    tx_mode = TX_RESP;
    step();
    s0 = strobes;
    drive_push(8'($urandom));
    check("c_pushpop_count", 32'(count_o), 32'd3);
    check("c_pushpop_strobe", 32'(strobes), 32'(s0 + 1));
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) drive_push(8'($urandom));
      else step();
      check_status("c_rand");
    end
    wait_strobes("c_drain", pushed, 600);
    repeat (10) step();

    // Transmitter that never goes busy: timeout paces the strobes.
    tx_mode = TX_NEVER;
    step();
    first = strobe_cyc.size();
    t0 = cyc;
    for (int i = 0; i < 3; i++) drive_push(8'(8'hC0 + i));
    wait_strobes("d_drain", pushed, 100);
    check("d_first", 32'(strobe_cyc[first]), 32'(t0 + 2));
    check("d_gap1", 32'(strobe_cyc[first+1] - strobe_cyc[first]), 32'(BUSY_TIMEOUT + 2));
    check("d_gap2", 32'(strobe_cyc[first+2] - strobe_cyc[first+1]), 32'(BUSY_TIMEOUT + 2));
    repeat (10) step();

    // Asynchronous reset while a frame is in flight with 5 bytes queued.
    tx_mode = TX_RESP;
    frame_len = 10;
    step();
    for (int i = 0; i < 6; i++) drive_push(8'(8'h50 + i));
    check("e_count5", 32'(count_o), 32'd5);
    reset_i = 1'b0;
    #1;
    exp_q.delete();
    pushed = strobes;
    check_status("e_rst");
    check("e_rst_write", 32'(uart_write_o), 32'd0);
    check("e_rst_data", 32'(uart_data_o), 32'h00);
    tx_mode = TX_NEVER;
    step();
    reset_i = 1'b1;
    s0 = strobes;
    repeat (10) step();
    check("e_no_strobe", 32'(strobes), 32'(s0));
    check_status("e_idle");
    first = strobe_cyc.size();
    t0 = cyc;
    drive_push(8'h77);
    wait_strobes("e_restart", pushed, 20);
    check("e_latency", 32'(strobe_cyc[first]), 32'(t0 + 2));
    repeat (10) step();

`ifdef UART_TX_FIFO_FLUSH_EN
    // Flush with 7 queued and a simultaneous push; in-flight byte survives.
    tx_mode = TX_RESP;
    frame_len = 10;
    step();
    for (int i = 0; i < 8; i++) drive_push(8'(8'h90 + i));
    check("f_count7", 32'(count_o), 32'd7);
    flush_i = 1'b1;
    data_i  = 8'h5A;
    valid_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    pushed = strobes;
    check_status("f_flushed");
    s0 = strobes;
    repeat (30) step();
    check("f_no_strobe", 32'(strobes), 32'(s0));
    check("f_inflight_data", 32'(uart_data_o), 32'h90);
    check_status("f_end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
